// File: rtl/lbm_moment_acc_if.sv
// Start/Done handshake and packed node-data bus between the node sequencer
// (master) and the D2Q9 moment accumulator (slave).
interface lbm_moment_acc_if #(
  parameter int WIDTH = 32,
  parameter int Q     = 9
);
  logic                 start;
  logic [WIDTH*Q-1:0]   fIn;
  logic [WIDTH*Q-1:0]   cxIn;
  logic [WIDTH*Q-1:0]   cyIn;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     rho;
  logic [WIDTH-1:0]     mx;
  logic [WIDTH-1:0]     my;

  modport master (
    output start, fIn, cxIn, cyIn,
    input  busy, done, rho, mx, my
  );

  modport slave (
    input  start, fIn, cxIn, cyIn,
    output busy, done, rho, mx, my
  );
endinterface

// File: rtl/lbm_moment_acc.sv
// Sequential D2Q9 moment accumulator: rho = sum f_i, mx = sum f_i*cx_i,
// my = sum f_i*cy_i in signed 8.24, one lattice direction per cycle.
module lbm_moment_acc #(
  parameter int WIDTH = 32,
  parameter int Q     = 9
) (
  input logic              i_clk,
  input logic              i_reset,
  lbm_moment_acc_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [3:0]              r_idx;
  logic [WIDTH-1:0]        r_f  [Q];
  logic [WIDTH-1:0]        r_cx [Q];
  logic [WIDTH-1:0]        r_cy [Q];
  logic [WIDTH-1:0]        r_accRho;
  logic [WIDTH-1:0]        r_accMx;
  logic [WIDTH-1:0]        r_accMy;
  logic [WIDTH-1:0]        r_rho;
  logic [WIDTH-1:0]        r_mx;
  logic [WIDTH-1:0]        r_my;
  logic                    r_done;

  logic [WIDTH-1:0]        w_f;
  logic [WIDTH-1:0]        w_cx;
  logic [WIDTH-1:0]        w_cy;
  logic [2*WIDTH-1:0]      w_prodX;
  logic [2*WIDTH-1:0]      w_prodY;
  logic [WIDTH-1:0]        w_termX;
  logic [WIDTH-1:0]        w_termY;
  logic                    w_last;

  always_comb begin
    w_f  = '0;
    w_cx = '0;
    w_cy = '0;
    for (int i = 0; i < Q; i++) begin
      if (r_idx == 4'(i)) begin
        w_f  = r_f[i];
        w_cx = r_cx[i];
        w_cy = r_cy[i];
      end
    end
  end

  // Sign-extended operands give the exact signed product in the low 2*WIDTH bits;
  // dropping the low 24 bits is a floor shift with no rounding.
  assign w_prodX = {{WIDTH{w_f[WIDTH-1]}}, w_f} * {{WIDTH{w_cx[WIDTH-1]}}, w_cx};
  assign w_prodY = {{WIDTH{w_f[WIDTH-1]}}, w_f} * {{WIDTH{w_cy[WIDTH-1]}}, w_cy};
  assign w_termX = w_prodX[WIDTH+23:24];
  assign w_termY = w_prodY[WIDTH+23:24];
  assign w_last  = (r_idx == 4'(Q-1));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = ACC;
      ACC:     if (w_last)    w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx    <= '0;
      r_accRho <= '0;
      r_accMx  <= '0;
      r_accMy  <= '0;
      r_rho    <= '0;
      r_mx     <= '0;
      r_my     <= '0;
      r_done   <= 1'b0;
      for (int i = 0; i < Q; i++) begin
        r_f[i]  <= '0;
        r_cx[i] <= '0;
        r_cy[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_idx    <= '0;
            r_accRho <= '0;
            r_accMx  <= '0;
            r_accMy  <= '0;
            for (int i = 0; i < Q; i++) begin
              r_f[i]  <= bus.fIn[WIDTH*i +: WIDTH];
              r_cx[i] <= bus.cxIn[WIDTH*i +: WIDTH];
              r_cy[i] <= bus.cyIn[WIDTH*i +: WIDTH];
            end
          end
        end
        ACC: begin
          // Results are published only on the final term so outputs hold between nodes.
          if (w_last) begin
            r_rho  <= r_accRho + w_f;
            r_mx   <= r_accMx + w_termX;
            r_my   <= r_accMy + w_termY;
            r_done <= 1'b1;
            r_idx  <= '0;
          end else begin
            r_accRho <= r_accRho + w_f;
            r_accMx  <= r_accMx + w_termX;
            r_accMy  <= r_accMy + w_termY;
            r_idx    <= r_idx + 4'd1;
          end
        end
        DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;
  assign bus.rho  = r_rho;
  assign bus.mx   = r_mx;
  assign bus.my   = r_my;

endmodule

// File: tb/tb_lbm_moment_acc.sv
// Directed self-checking bench for lbm_moment_acc: reset, moment sums,
// floor truncation, modulo wrap, input latching, ignored Start and mid-run reset.
module tb_lbm_moment_acc;

  localparam int WIDTH = 32;
  localparam int Q     = 9;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;

  logic [WIDTH-1:0] fV  [Q];
  logic [WIDTH-1:0] cxV [Q];
  logic [WIDTH-1:0] cyV [Q];

  lbm_moment_acc_if #(.WIDTH(WIDTH), .Q(Q)) busIf ();

  lbm_moment_acc #(.WIDTH(WIDTH), .Q(Q)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (busIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearVec();
    for (int i = 0; i < Q; i++) begin
      fV[i]  = '0;
      cxV[i] = '0;
      cyV[i] = '0;
    end
  endtask

  task automatic loadVec();
    for (int i = 0; i < Q; i++) begin
      busIf.fIn[WIDTH*i +: WIDTH]  = fV[i];
      busIf.cxIn[WIDTH*i +: WIDTH] = cxV[i];
      busIf.cyIn[WIDTH*i +: WIDTH] = cyV[i];
    end
  endtask

  // Pulse Start for one edge (E0) and return the number of edges until Done, 0 on timeout.
  task automatic runNode(output int cycles);
    loadVec();
    @(posedge clk); #1 busIf.start = 1'b1;
    @(posedge clk); #1 busIf.start = 1'b0;
    cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busIf.done) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      testsRun++;
      if ({busIf.busy, busIf.done, busIf.rho, busIf.mx, busIf.my} !== {2'b00, 96'h0}) begin
        $display("[TB] FAIL reset_idle cycle %0d: got busy=%b done=%b rho=%h mx=%h my=%h expected all zero",
                 k, busIf.busy, busIf.done, busIf.rho, busIf.mx, busIf.my);
        testsFailed++;
      end
    end
  endtask

  task automatic test_uniform();
    int cycles;
    clearVec();
    for (int i = 0; i < Q; i++) fV[i] = 32'h0100_0000;
    cxV[0] = 32'h0100_0000; cxV[1] = 32'hFF00_0000; cxV[2] = 32'hFF00_0000;
    cxV[3] = 32'h0100_0000; cxV[5] = 32'hFF00_0000; cxV[7] = 32'h0100_0000;
    cyV[2] = 32'h0100_0000; cyV[4] = 32'hFF00_0000; cyV[5] = 32'h0100_0000;
    cyV[6] = 32'h0100_0000; cyV[7] = 32'hFF00_0000; cyV[8] = 32'hFF00_0000;
    runNode(cycles);
    testsRun++;
    if (cycles !== 9) begin
      $display("[TB] FAIL uniform_latency: got %0d expected 9", cycles); testsFailed++;
    end
    testsRun++;
    if (busIf.busy !== 1'b1) begin
      $display("[TB] FAIL uniform_busy_at_done: got %b expected 1", busIf.busy); testsFailed++;
    end
    testsRun++;
    if (busIf.rho !== 32'h0900_0000) begin
      $display("[TB] FAIL uniform_rho: got %h expected 09000000", busIf.rho); testsFailed++;
    end
    testsRun++;
    if (busIf.mx !== 32'h0) begin
      $display("[TB] FAIL uniform_mx: got %h expected 00000000", busIf.mx); testsFailed++;
    end
    testsRun++;
    if (busIf.my !== 32'h0) begin
      $display("[TB] FAIL uniform_my: got %h expected 00000000", busIf.my); testsFailed++;
    end
    @(posedge clk); #1;
    testsRun++;
    if ({busIf.busy, busIf.done} !== 2'b00) begin
      $display("[TB] FAIL uniform_after_done: got busy=%b done=%b expected 0 0", busIf.busy, busIf.done);
      testsFailed++;
    end
    repeat (3) @(posedge clk); #1;
    testsRun++;
    if (busIf.rho !== 32'h0900_0000) begin
      $display("[TB] FAIL uniform_hold_rho: got %h expected 09000000", busIf.rho); testsFailed++;
    end
  endtask

  task automatic test_mixed();
    int cycles;
    clearVec();
    fV[1] = 32'h0200_0000; cxV[1] = 32'h0100_0000;
    fV[2] = 32'h0040_0000; cxV[2] = 32'h0100_0000; cyV[2] = 32'hFF00_0000;
    runNode(cycles);
    testsRun++;
    if ({busIf.rho, busIf.mx, busIf.my} !== {32'h0240_0000, 32'h0240_0000, 32'hFFC0_0000}) begin
      $display("[TB] FAIL mixed_moments: got rho=%h mx=%h my=%h expected 02400000 02400000 ffc00000",
               busIf.rho, busIf.mx, busIf.my);
      testsFailed++;
    end
  endtask

  task automatic test_sign_fraction();
    int cycles;
    clearVec();
    fV[0] = 32'h0080_0000; cxV[0] = 32'hFF00_0000;
    runNode(cycles);
    testsRun++;
    if (cycles !== 9) begin
      $display("[TB] FAIL sign_latency: got %0d expected 9", cycles); testsFailed++;
    end
    testsRun++;
    if ({busIf.rho, busIf.mx, busIf.my} !== {32'h0080_0000, 32'hFF80_0000, 32'h0}) begin
      $display("[TB] FAIL sign_fraction: got rho=%h mx=%h my=%h expected 00800000 ff800000 00000000",
               busIf.rho, busIf.mx, busIf.my);
      testsFailed++;
    end
  endtask

  task automatic test_truncation();
    int cycles;
    clearVec();
    fV[0] = 32'h0000_0001; cxV[0] = 32'h0080_0000;
    runNode(cycles);
    testsRun++;
    if (busIf.mx !== 32'h0000_0000) begin
      $display("[TB] FAIL trunc_pos: got %h expected 00000000", busIf.mx); testsFailed++;
    end
    cxV[0] = 32'hFF80_0000;
    runNode(cycles);
    testsRun++;
    if (busIf.mx !== 32'hFFFF_FFFF) begin
      $display("[TB] FAIL trunc_neg: got %h expected ffffffff", busIf.mx); testsFailed++;
    end
    testsRun++;
    if (busIf.rho !== 32'h0000_0001) begin
      $display("[TB] FAIL trunc_rho: got %h expected 00000001", busIf.rho); testsFailed++;
    end
  endtask

  task automatic test_wrap_latch();
    int  cycles;
    bit  sawDone;
    clearVec();
    for (int i = 0; i < Q; i++) fV[i] = 32'h7F00_0000;
    loadVec();
    @(posedge clk); #1 busIf.start = 1'b1;
    @(posedge clk); #1 busIf.start = 1'b0;
    clearVec();
    loadVec();
    cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 3) busIf.start = 1'b1;
      if (k == 4) busIf.start = 1'b0;
      if (busIf.done) begin
        cycles = k;
        break;
      end
    end
    testsRun++;
    if (cycles !== 9) begin
      $display("[TB] FAIL wrap_latency: got %0d expected 9", cycles); testsFailed++;
    end
    testsRun++;
    if (busIf.rho !== 32'h7700_0000) begin
      $display("[TB] FAIL wrap_rho: got %h expected 77000000", busIf.rho); testsFailed++;
    end
    sawDone = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (busIf.done) sawDone = 1'b1;
    end
    testsRun++;
    if (sawDone !== 1'b0) begin
      $display("[TB] FAIL start_ignored_in_acc: got second done=%b expected 0", sawDone); testsFailed++;
    end
  endtask

  task automatic test_reset_mid();
    int  cycles;
    bit  sawDone;
    clearVec();
    for (int i = 0; i < Q; i++) fV[i] = 32'h0100_0000;
    loadVec();
    @(posedge clk); #1 busIf.start = 1'b1;
    @(posedge clk); #1 busIf.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    testsRun++;
    if ({busIf.busy, busIf.done, busIf.rho, busIf.mx, busIf.my} !== {2'b00, 96'h0}) begin
      $display("[TB] FAIL reset_mid: got busy=%b done=%b rho=%h mx=%h my=%h expected all zero",
               busIf.busy, busIf.done, busIf.rho, busIf.mx, busIf.my);
      testsFailed++;
    end
    sawDone = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (busIf.done || busIf.busy) sawDone = 1'b1;
    end
    testsRun++;
    if (sawDone !== 1'b0) begin
      $display("[TB] FAIL reset_mid_no_done: got activity=%b expected 0", sawDone); testsFailed++;
    end
    clearVec();
    fV[0] = 32'h0080_0000; cxV[0] = 32'hFF00_0000;
    runNode(cycles);
    testsRun++;
    if (cycles !== 9) begin
      $display("[TB] FAIL after_reset_latency: got %0d expected 9", cycles); testsFailed++;
    end
    testsRun++;
    if ({busIf.rho, busIf.mx} !== {32'h0080_0000, 32'hFF80_0000}) begin
      $display("[TB] FAIL after_reset_values: got rho=%h mx=%h expected 00800000 ff800000",
               busIf.rho, busIf.mx);
      testsFailed++;
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b0;
    busIf.start = 1'b0;
    busIf.fIn   = '0;
    busIf.cxIn  = '0;
    busIf.cyIn  = '0;
    test_reset();
    test_uniform();
    test_mixed();
    test_sign_fraction();
    test_truncation();
    test_wrap_latch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/lbm_moment_acc.md
# lbm_moment_acc

Sequential macroscopic-moment accumulator for the D2Q9 lattice-Boltzmann datapath. It consumes one node's nine packed distribution values together with the packed lattice-velocity vectors (cx, cy) produced by the constant velocity-vector blocks. Over nine cycles it computes density rho = Σf_i and momenta mx = Σf_i·cx_i, my = Σf_i·cy_i in signed 8.24 fixed point. It sits between the node-state memory read port and the equilibrium/collision stage, with a Start/Done handshake to the node sequencer.

## Interface
- WIDTH, 32: bit width of one lattice value, signed 8.24 (0x01_000000 = +1.0, 0xFF_000000 = −1.0).
- Q, 9: number of lattice directions.
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request to begin one accumulation; sampled only in IDLE.
- F_In  input  WIDTH*Q  packed signed f_i; slice i = bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- Cx_In  input  WIDTH*Q  packed signed cx_i, same slicing.
- Cy_In  input  WIDTH*Q  packed signed cy_i, same slicing.
- Busy  output  1  high whenever state ≠ IDLE.
- Done  output  1  one-cycle pulse: results valid.
- Rho  output  WIDTH  signed Σf_i.
- Mx  output  WIDTH  signed Σf_i·cx_i.
- My  output  WIDTH  signed Σf_i·cy_i.

## Operation
- States: IDLE, ACC, DONE. Index counter idx is 4 bits, range 0..Q−1.
- IDLE: when Start=1 at a clock edge, latch F_In/Cx_In/Cy_In into internal shadow registers, clear the accumulators, set idx=0, and go to ACC. Input changes after the Start edge have no effect.
- ACC: each edge adds slice idx into the three accumulators and increments idx. At idx=Q−1, load Rho/Mx/My with the final sums (accumulator plus the last term), set Done=1, and go to DONE.
- DONE: on the next edge clear Done and go to IDLE.
- Product: signed WIDTH×WIDTH → 2·WIDTH-bit full product. The term is bits [WIDTH+23 : 24], an arithmetic shift right by 24 that rounds toward −∞; no rounding correction.
- Accumulation: WIDTH-bit two's complement, modulo 2^WIDTH. Overflow wraps; there is no saturation and no overflow flag.
- Rho adds f_i directly, with no multiply.
- Rho/Mx/My change only at the final ACC edge. They hold their value until the next completion or until reset.
- Start while Busy=1 (ACC or DONE) is ignored and not queued.
- Reset has priority over every state. It forces IDLE, idx=0, clears the accumulators and shadow registers, and sets Busy=0, Done=0, Rho=0, Mx=0, My=0. Reset mid-ACC aborts the computation, and no Done is produced for it.

## Timing
- E0 = the edge sampling Start=1 in IDLE. Busy is 1 from after E0 until after E10.
- E1..E9 accumulate idx 0..8. After E9: Done=1 and the outputs are valid.
- After E10: Done=0 and the block is in IDLE. The earliest next Start is sampled at E11, so throughput is one node per 11 cycles.
- Start-to-Done latency: 9 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then idle: hold Reset=1 for 2 cycles, then release with Start=0 → Busy=0, Done=0, Rho=Mx=My=0 indefinitely.
- Uniform rest node: all f_i=0x01_000000, Cx = {0,+1,0,−1,0,+1,−1,−1,+1} (slice 8 down to slice 0) in 8.24, Cy set likewise with sum 0, Start pulsed → Done exactly 9 cycles later; Rho=0x09_000000, Mx=0, My=0.
- Sign and fraction: f_0=0x00_800000 (0.5), other f_i=0, cx_0=0xFF_000000 → Rho=0x00_800000, Mx=0xFF_800000 (−0.5).
- Truncation toward −∞: f_0=0x0000_0001, cx_0=0x00_800000 → Mx=0x0000_0000. Then cx_0=0xFF_800000 → Mx=0xFFFF_FFFF.
- Wrap and input latching: all f_i=0x7F_000000 with Start, and F_In changed to 0 on the cycle after Start → Rho=0x77_000000 (modulo wrap). A Start pulse re-asserted during ACC produces no second Done.
- Reset mid-operation: assert Reset at E4 → next cycle Busy=0 and all outputs 0, with no Done. A fresh Start afterwards completes normally with correct values.
